// File: rtl/xgmii_rx_decoder_if.sv
// Frame-word bus from the XGMII receive decoder: one strobed 64-bit word with sop/eop/mod/err tags.
// The producer drives every field; there is no ready, so the consumer must take each strobed word.
interface xgmii_rx_decoder_if;
    logic        Pkt_valid;
    logic [63:0] Pkt_data;
    logic        Pkt_sop;
    logic        Pkt_eop;
    logic [2:0]  Pkt_mod;
    logic        Pkt_err;

    modport master (
        output Pkt_valid, Pkt_data, Pkt_sop, Pkt_eop, Pkt_mod, Pkt_err
    );

    modport slave (
        input Pkt_valid, Pkt_data, Pkt_sop, Pkt_eop, Pkt_mod, Pkt_err
    );
endinterface

// File: rtl/xgmii_rx_decoder.sv
// XGMII receive framer: strips Start/preamble, tags words sop/eop/mod/err; stats built only with XGMII_RX_DECODER_STAT_EN.
// Latency 2 cycles from input sample to Pkt_*; no backpressure, Pkt_valid is a pure strobe.
module xgmii_rx_decoder #(
    parameter int MAX_LEN_WORDS = 255
) (
    input  logic                 Xgmii_rxclk,
    input  logic                 Rst_rx_n,
    input  logic [63:0]          Xgmii_rxd,
    input  logic [7:0]           Xgmii_rxc,
    input  logic                 CntClr,
    xgmii_rx_decoder_if.master   pkt,
    output logic [31:0]          Frm_cnt,
    output logic [15:0]          Err_cnt
);
    localparam int CW = $clog2(MAX_LEN_WORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [63:0]   s0_d_q;
    logic [7:0]    s0_c_q;
    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [63:0]   hold_dat_q, hold_dat_d;
    logic          hold_vld_q, hold_vld_d;
    logic          hold_sop_q, hold_sop_d;
    logic          hold_eop_q, hold_eop_d;
    logic [2:0]    hold_mod_q, hold_mod_d;
    logic          pkt_vld_q,  pkt_vld_d;
    logic [63:0]   pkt_dat_q,  pkt_dat_d;
    logic          pkt_sop_q,  pkt_sop_d;
    logic          pkt_eop_q,  pkt_eop_d;
    logic [2:0]    pkt_mod_q,  pkt_mod_d;
    logic          pkt_err_q,  pkt_err_d;
    logic          lost_q,     lost_d;

    logic [2:0]    first_idx;
    logic          is_start, is_term, has_term;
    logic          emit, emit_eop, emit_err;
    logic [2:0]    emit_mod;

    // Lowest control lane decides the word's meaning; anything but FD there is an error.
    always_comb begin
        first_idx = 3'd0;
        has_term  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (s0_c_q[i]) begin
                first_idx = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (s0_c_q[i] && (s0_d_q[8*i +: 8] == 8'hFD)) begin
                has_term = 1'b1;
            end
        end
        is_term  = (|s0_c_q) && (s0_d_q[8*first_idx +: 8] == 8'hFD);
        is_start = (s0_c_q == 8'h01) && (s0_d_q[7:0] == 8'hFB);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_dat_d = hold_dat_q;
        hold_vld_d = hold_vld_q;
        hold_sop_d = hold_sop_q;
        hold_eop_d = hold_eop_q;
        hold_mod_d = hold_mod_q;
        emit       = 1'b0;
        emit_eop   = 1'b0;
        emit_err   = 1'b0;
        emit_mod   = 3'd0;
        lost_d     = 1'b0;

        // A word held with a pending eop is flushed on the cycle after its Terminate.
        if (hold_eop_q) begin
            emit       = 1'b1;
            emit_eop   = 1'b1;
            emit_mod   = hold_mod_q;
            hold_vld_d = 1'b0;
            hold_eop_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (is_start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (s0_c_q == 8'h00) begin
                    if (cnt_q == MAX_CNT) begin
                        emit       = 1'b1;
                        emit_eop   = 1'b1;
                        emit_err   = 1'b1;
                        emit_mod   = 3'd7;
                        hold_vld_d = 1'b0;
                        state_d    = DROP;
                    end else begin
                        emit       = hold_vld_q;
                        hold_dat_d = s0_d_q;
                        hold_vld_d = 1'b1;
                        hold_sop_d = (cnt_q == '0);
                        cnt_d      = cnt_q + 1'b1;
                    end
                end else if (is_term && (first_idx == 3'd0)) begin
                    state_d    = IDLE;
                    emit       = hold_vld_q;
                    emit_eop   = 1'b1;
                    emit_mod   = 3'd7;
                    hold_vld_d = 1'b0;
                    lost_d     = ~hold_vld_q;
                end else if (is_term) begin
                    state_d = IDLE;
                    if (cnt_q == MAX_CNT) begin
                        emit       = 1'b1;
                        emit_eop   = 1'b1;
                        emit_err   = 1'b1;
                        emit_mod   = 3'd7;
                        hold_vld_d = 1'b0;
                    end else begin
                        emit       = hold_vld_q;
                        hold_dat_d = s0_d_q;
                        hold_vld_d = 1'b1;
                        hold_sop_d = (cnt_q == '0);
                        hold_eop_d = 1'b1;
                        hold_mod_d = first_idx - 3'd1;
                        cnt_d      = cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = IDLE;
                    emit       = hold_vld_q;
                    emit_eop   = 1'b1;
                    emit_err   = 1'b1;
                    emit_mod   = 3'd7;
                    hold_vld_d = 1'b0;
                    lost_d     = ~hold_vld_q;
                end
            end
            DROP: begin
                if (has_term || (s0_c_q == 8'hFF)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pkt_vld_d = emit;
        pkt_dat_d = emit ? hold_dat_q : 64'd0;
        pkt_sop_d = emit & hold_sop_q;
        pkt_eop_d = emit & emit_eop;
        pkt_mod_d = emit ? emit_mod : 3'd0;
        pkt_err_d = emit & emit_err;
    end

    always_ff @(posedge Xgmii_rxclk or negedge Rst_rx_n) begin
        if (!Rst_rx_n) begin
            s0_d_q     <= '0;
            s0_c_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_dat_q <= '0;
            hold_vld_q <= 1'b0;
            hold_sop_q <= 1'b0;
            hold_eop_q <= 1'b0;
            hold_mod_q <= '0;
            pkt_vld_q  <= 1'b0;
            pkt_dat_q  <= '0;
            pkt_sop_q  <= 1'b0;
            pkt_eop_q  <= 1'b0;
            pkt_mod_q  <= '0;
            pkt_err_q  <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            s0_d_q     <= Xgmii_rxd;
            s0_c_q     <= Xgmii_rxc;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_dat_q <= hold_dat_d;
            hold_vld_q <= hold_vld_d;
            hold_sop_q <= hold_sop_d;
            hold_eop_q <= hold_eop_d;
            hold_mod_q <= hold_mod_d;
            pkt_vld_q  <= pkt_vld_d;
            pkt_dat_q  <= pkt_dat_d;
            pkt_sop_q  <= pkt_sop_d;
            pkt_eop_q  <= pkt_eop_d;
            pkt_mod_q  <= pkt_mod_d;
            pkt_err_q  <= pkt_err_d;
            lost_q     <= lost_d;
        end
    end

    assign pkt.Pkt_valid = pkt_vld_q;
    assign pkt.Pkt_data  = pkt_dat_q;
    assign pkt.Pkt_sop   = pkt_sop_q;
    assign pkt.Pkt_eop   = pkt_eop_q;
    assign pkt.Pkt_mod   = pkt_mod_q;
    assign pkt.Pkt_err   = pkt_err_q;

`ifdef XGMII_RX_DECODER_STAT_EN
    logic [31:0] frm_cnt_q, frm_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Counters follow the registered eop by one cycle so CntClr seen alongside Pkt_eop wins.
    always_comb begin
        frm_cnt_d = frm_cnt_q;
        err_cnt_d = err_cnt_q;
        if (CntClr) begin
            frm_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            if (pkt_vld_q && pkt_eop_q && !pkt_err_q && !(&frm_cnt_q)) begin
                frm_cnt_d = frm_cnt_q + 32'd1;
            end
            if (((pkt_vld_q && pkt_eop_q && pkt_err_q) || lost_q) && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Xgmii_rxclk or negedge Rst_rx_n) begin
        if (!Rst_rx_n) begin
            frm_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Frm_cnt = frm_cnt_q;
    assign Err_cnt = err_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = ^{CntClr, lost_q};
    assign Frm_cnt     = '0;
    assign Err_cnt     = '0;
`endif
endmodule

// File: tb/tb_xgmii_rx_decoder.sv
// Bench for xgmii_rx_decoder: frame-level byte model feeds a scoreboard queue; a monitor pops on Pkt_valid.
module tb_xgmii_rx_decoder;
    localparam int MAXW = 255;
`ifdef XGMII_RX_DECODER_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] dat;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } exp_t;

    logic        Xgmii_rxclk = 1'b0;
    logic        Rst_rx_n;
    logic [63:0] Xgmii_rxd;
    logic [7:0]  Xgmii_rxc;
    logic        CntClr;
    logic [31:0] Frm_cnt;
    logic [15:0] Err_cnt;

    xgmii_rx_decoder_if pkt_bus ();

    xgmii_rx_decoder #(.MAX_LEN_WORDS(MAXW)) dut (
        .Xgmii_rxclk (Xgmii_rxclk),
        .Rst_rx_n    (Rst_rx_n),
        .Xgmii_rxd   (Xgmii_rxd),
        .Xgmii_rxc   (Xgmii_rxc),
        .CntClr      (CntClr),
        .pkt         (pkt_bus),
        .Frm_cnt     (Frm_cnt),
        .Err_cnt     (Err_cnt)
    );

    always #5 Xgmii_rxclk = ~Xgmii_rxclk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   frm_exp  = 0;
    int   err_exp  = 0;

    // Scoreboard monitor: every strobed word must match the next expected word.
    always @(negedge Xgmii_rxclk) begin
        if (Rst_rx_n && pkt_bus.Pkt_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got data=%h sop=%b eop=%b mod=%0d err=%b, none expected",
                         pkt_bus.Pkt_data, pkt_bus.Pkt_sop, pkt_bus.Pkt_eop, pkt_bus.Pkt_mod, pkt_bus.Pkt_err);
            end else begin
                exp_t e;
                logic [63:0] mask;
                int nb;
                e    = exp_q.pop_front();
                nb   = e.eop ? (int'(e.mod) + 1) : 8;
                mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
                if (((pkt_bus.Pkt_data & mask) != (e.dat & mask)) || (pkt_bus.Pkt_sop != e.sop) ||
                    (pkt_bus.Pkt_eop != e.eop) || (pkt_bus.Pkt_mod != e.mod) || (pkt_bus.Pkt_err != e.err)) begin
                    failures++;
                    $display("FAIL word got data=%h sop=%b eop=%b mod=%0d err=%b, want data=%h sop=%b eop=%b mod=%0d err=%b",
                             pkt_bus.Pkt_data & mask, pkt_bus.Pkt_sop, pkt_bus.Pkt_eop, pkt_bus.Pkt_mod, pkt_bus.Pkt_err,
                             e.dat & mask, e.sop, e.eop, e.mod, e.err);
                end
            end
        end
    end

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        @(negedge Xgmii_rxclk);
        Xgmii_rxd = d;
        Xgmii_rxc = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive({8{8'h07}}, 8'hFF);
    endtask

    task automatic check_cnt(input string name);
        int fe;
        int ee;
        fe = STAT ? frm_exp : 0;
        ee = STAT ? err_exp : 0;
        checks += 2;
        if (Frm_cnt != 32'(fe)) begin
            failures++;
            $display("FAIL %s Frm_cnt got %0d want %0d", name, Frm_cnt, fe);
        end
        if (Err_cnt != 16'(ee)) begin
            failures++;
            $display("FAIL %s Err_cnt got %0d want %0d", name, Err_cnt, ee);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({pkt_bus.Pkt_valid, pkt_bus.Pkt_sop, pkt_bus.Pkt_eop, pkt_bus.Pkt_err} != 4'b0 ||
            pkt_bus.Pkt_mod != 3'd0 || pkt_bus.Pkt_data != 64'd0) begin
            failures++;
            $display("FAIL %s outputs got vld=%b sop=%b eop=%b err=%b mod=%0d data=%h, want all zero", name,
                     pkt_bus.Pkt_valid, pkt_bus.Pkt_sop, pkt_bus.Pkt_eop, pkt_bus.Pkt_err, pkt_bus.Pkt_mod, pkt_bus.Pkt_data);
        end
        frm_exp = 0;
        err_exp = 0;
        check_cnt(name);
    endtask

    // len payload bytes; err_pos >= 0 replaces that byte with an /E/ control character.
    task automatic send_frame(input int len, input int err_pos);
        logic [7:0]  b[$];
        logic [63:0] d;
        logic [7:0]  c;
        exp_t        e;
        int          nw;
        int          pos;
        bit          bad;
        for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
        nw  = (err_pos >= 0) ? (err_pos / 8) : ((len + 7) / 8);
        bad = (err_pos >= 0) || (nw > MAXW) || (len == 0);
        if (nw > MAXW) nw = MAXW;
        for (int w = 0; w < nw; w++) begin
            for (int l = 0; l < 8; l++) begin
                pos = w * 8 + l;
                e.dat[8*l +: 8] = (pos < len) ? b[pos] : 8'h00;
            end
            e.sop = (w == 0);
            e.eop = (w == nw - 1);
            e.err = e.eop && bad;
            e.mod = !e.eop ? 3'd0 : (bad ? 3'd7 : 3'((len - 1) % 8));
            exp_q.push_back(e);
        end
        if (bad) err_exp++;
        else     frm_exp++;
        drive({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01);
        for (int w = 0; w <= len / 8; w++) begin
            for (int l = 0; l < 8; l++) begin
                pos = w * 8 + l;
                if (pos == err_pos)  begin d[8*l +: 8] = 8'hFE;  c[l] = 1'b1; end
                else if (pos < len)  begin d[8*l +: 8] = b[pos]; c[l] = 1'b0; end
                else if (pos == len) begin d[8*l +: 8] = 8'hFD;  c[l] = 1'b1; end
                else                 begin d[8*l +: 8] = 8'h07;  c[l] = 1'b1; end
            end
            drive(d, c);
        end
    endtask

    initial begin
        bit seen;
        int len;
        int ep;
        Rst_rx_n  = 1'b0;
        Xgmii_rxd = {8{8'h07}};
        Xgmii_rxc = 8'hFF;
        CntClr    = 1'b0;
        repeat (3) @(negedge Xgmii_rxclk);
        check_zero("reset");
        Rst_rx_n = 1'b1;
        idle(4);

        send_frame(67, -1);
        idle(6);
        check_cnt("nine_words_lane3");

        send_frame(32, -1);
        idle(6);
        check_cnt("term_lane0");

        send_frame(40, 29);
        idle(3);
        send_frame(20, -1);
        idle(6);
        check_cnt("fe_error_then_good");

        send_frame(16, -1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive({8{8'h07}}, 8'hFF);
            if (pkt_bus.Pkt_valid && pkt_bus.Pkt_eop) begin
                seen   = 1'b1;
                CntClr = 1'b1;
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL cntclr_wait got no eop within 20 cycles, want one");
        end
        drive({8{8'h07}}, 8'hFF);
        CntClr  = 1'b0;
        frm_exp = 0;
        err_exp = 0;
        idle(4);
        check_cnt("cntclr_with_eop");

        send_frame(2400, -1);
        idle(6);
        check_cnt("oversize");

        send_frame(0, -1);
        idle(4);
        check_cnt("empty_frame");

        drive({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01);
        drive(64'h0123_4567_89AB_CDEF, 8'h00);
        @(negedge Xgmii_rxclk);
        Rst_rx_n = 1'b0;
        @(negedge Xgmii_rxclk);
        check_zero("reset_mid_frame");
        Rst_rx_n = 1'b1;
        repeat (3) drive({$urandom, $urandom}, 8'h00);
        drive({{7{8'h07}}, 8'hFD}, 8'hFF);
        idle(4);
        send_frame(24, -1);
        idle(6);
        check_cnt("after_reset");

        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 90));
            ep  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            send_frame(len, ep);
            idle(int'($urandom_range(1, 4)));
        end
        idle(8);
        check_cnt("random_frames");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d words still expected, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xgmii_rx_decoder.md
XGMII_RX_DECODER -- requirements
Module: xgmii_rx_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN_WORDS, default 255: maximum forwarded data words per frame.
REQ-002 SHALL have input Xgmii_rxclk (1 bit): receive clock; all logic on its rising edge.
REQ-003 SHALL have input Rst_rx_n (1 bit): reset; asynchronous, active-low.
REQ-004 SHALL have input Xgmii_rxd (64 bits): XGMII receive data, lane i = bits [8i+7:8i].
REQ-005 SHALL have input Xgmii_rxc (8 bits): XGMII control flags, bit i marks lane i as a control character.
REQ-006 SHALL have input CntClr (1 bit): synchronous clear of the statistics counters.
REQ-007 SHALL have output Pkt_valid (1 bit): Pkt_* fields valid this cycle; there is no backpressure.
REQ-008 SHALL have output Pkt_data (64 bits): frame payload word, lane 0 = first byte.
REQ-009 SHALL have output Pkt_sop (1 bit): first word of a frame.
REQ-010 SHALL have output Pkt_eop (1 bit): last word of a frame.
REQ-011 SHALL have output Pkt_mod (3 bits): on eop, number of valid bytes minus 1; otherwise 0.
REQ-012 SHALL have output Pkt_err (1 bit): on eop, the frame is errored and must be discarded downstream.
REQ-013 SHALL have output Frm_cnt (32 bits): count of good frames.
REQ-014 SHALL have output Err_cnt (16 bits): count of errored or dropped frames.

Function
REQ-015 SHALL register Xgmii_rxd/Xgmii_rxc into stage 0, then hold one data word in stage 1 until the next word is seen, so terminate-in-lane-0 can be folded into the held word.
REQ-016 SHALL drive Pkt_* from registers, 2 cycles after the word's sampling edge (latency 2 from input to output).
REQ-017 SHALL implement states IDLE, DATA and DROP.
REQ-018 SHALL detect Start only as rxc==8'h01 with lane0==8'hFB; the Start/preamble word is not forwarded.
REQ-019 SHALL move IDLE->DATA on Start; the first following word is output with Pkt_sop=1.
REQ-020 SHALL define Terminate as the lowest lane i with rxc[i]=1 and lane value 8'hFD; all lower lanes must be data.
REQ-021 SHALL, on Terminate at lane i>0, output the held word (eop=0), then output the current word with eop=1, mod=i-1, and move DATA->IDLE.
REQ-022 SHALL, on Terminate at lane 0, output the held word with eop=1, mod=7, and move DATA->IDLE.
REQ-023 SHALL treat, in DATA, any control lane that is not a valid Terminate (including 8'hFE and a new Start) as an error: output the held word with eop=1, err=1, mod=7, then go to IDLE; a Start in that word is ignored.
REQ-024 SHALL count forwarded words, clearing the count at Start.
REQ-025 SHALL, when the word count would exceed MAX_LEN_WORDS, output the held word with eop=1, err=1 and go to DROP.
REQ-026 SHALL stay in DROP until a word containing Terminate, or rxc==8'hFF, then go to IDLE, with no output while in DROP.
REQ-027 SHALL, for Start immediately followed by Terminate in lane 0 (empty frame), output nothing and increment Err_cnt.
REQ-028 SHALL increment Frm_cnt on each eop with err=0.
REQ-029 SHALL increment Err_cnt on each eop with err=1 and on each empty frame.
REQ-030 SHALL make both counters saturate at all-ones; CntClr has priority over increment.
REQ-031 SHALL have sop and eop both set on a single-word frame.

Reset
REQ-032 SHALL, on Rst_rx_n low: state IDLE, pipeline flushed, Pkt_valid/sop/eop/err=0, Pkt_data=0, Pkt_mod=0, counters 0.
REQ-033 SHALL, on reset asserted mid-frame, discard the frame silently; after release, the first frame is accepted only from a fresh Start.

Configuration
REQ-034 SHALL, with macro XGMII_RX_DECODER_STAT_EN defined, implement Frm_cnt and Err_cnt as above.
REQ-035 SHALL, without XGMII_RX_DECODER_STAT_EN, tie Frm_cnt and Err_cnt to 0, ignore CntClr and leave framing behaviour unchanged.

Verification
REQ-036 SHALL verify: Idle, Start word, 8 data words, FD in lane 3 -> 9 valid words, sop on first, eop on ninth with mod=2, err=0; Frm_cnt=1.
REQ-037 SHALL verify: frame whose Terminate sits in lane 0 after 4 data words -> 4 words, eop on fourth with mod=7.
REQ-038 SHALL verify: 8'hFE error code in lane 5 mid-frame -> eop, err=1, mod=7 on the preceding word; Err_cnt=1; the next good frame passes.
REQ-039 SHALL verify: 300 data words with MAX_LEN_WORDS=255 -> 255 words, last with eop=1, err=1; nothing more until the following Start.
REQ-040 SHALL verify: Start then Terminate in lane 0 -> no Pkt_valid, Err_cnt increments; reset pulse mid-frame -> outputs 0 and no stray eop.
REQ-041 SHALL verify: CntClr asserted in the same cycle as a good eop -> Frm_cnt=0; build without the macro -> counters remain 0.
